// File: rtl/run_ctrl_stats_pkg.sv
// Shared run-controller definitions: FSM state codes, statistic select codes
// and the core-enable rule, kept next to the core definitions.
// Used by run_ctrl_stats and its testbench.
package run_ctrl_stats_pkg;

  localparam int RC_STAT_SEL_BIT = 2;

  localparam logic [1:0] RC_ST_PAUSE = 2'd0;
  localparam logic [1:0] RC_ST_RUN   = 2'd1;
  localparam logic [1:0] RC_ST_STEP  = 2'd2;
  localparam logic [1:0] RC_ST_HALT  = 2'd3;

  localparam logic [RC_STAT_SEL_BIT-1:0] RC_STAT_SEL_CYC = 2'd0;
  localparam logic [RC_STAT_SEL_BIT-1:0] RC_STAT_SEL_JMP = 2'd1;
  localparam logic [RC_STAT_SEL_BIT-1:0] RC_STAT_SEL_BR  = 2'd2;
  localparam logic [RC_STAT_SEL_BIT-1:0] RC_STAT_SEL_BRT = 2'd3;

  // The core runs in RUN and STEP, but never in a cycle where it already reports halt.
  function automatic logic rc_core_en(input logic [1:0] st, input logic halted);
    return ((st == RC_ST_RUN) || (st == RC_ST_STEP)) && !halted;
  endfunction

endpackage

// File: rtl/run_ctrl_stats_btn_debounce.sv
// Purpose: 2-flop synchronizer plus level debouncer for one raw push-button.
// Latency: press pulse registered DebounceCycles+2 edges after the raw edge.
// Backpressure: none; press is a one-cycle pulse the consumer must take.
module btn_debounce #(
  parameter int DebounceCycles = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DebounceCycles);
  localparam logic [CW-1:0] LIM = CW'(DebounceCycles - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff  = (r_s2 != r_db);
  assign w_done  = w_diff && (r_cnt == LIM);
  assign o_press = r_press;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has differed for DebounceCycles edges in a row;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      if (w_done) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      r_press <= w_done && r_s2;
    end
  end

endmodule

// File: rtl/run_ctrl_stats.sv
// Purpose: run/pause/step/halt controller for the core plus execution statistics.
// Latency: cpu_en combinational from state and halted; stat_out 1 cycle after sel_stat.
// Backpressure: none; halted drops cpu_en in the same cycle it is seen.
module run_ctrl_stats
  import run_ctrl_stats_pkg::*;
#(
  parameter int DebounceCycles = 1000000,
  parameter int CntWidth       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_run,
  input  logic                       btn_step,
  input  logic                       halted,
  input  logic                       jumped,
  input  logic                       is_branch,
  input  logic                       branched,
  input  logic [RC_STAT_SEL_BIT-1:0] sel_stat,
  output logic                       cpu_en,
  output logic                       running,
  output logic                       is_halted,
  output logic [CntWidth-1:0]        stat_out
);

  logic                w_run_press;
  logic                w_step_press;
  logic                w_cpu_en;
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CntWidth-1:0] r_cyc_cnt;
  logic [CntWidth-1:0] r_jmp_cnt;
  logic [CntWidth-1:0] r_br_cnt;
  logic [CntWidth-1:0] r_brt_cnt;
  logic [CntWidth-1:0] r_stat;

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_db_run (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_run),
    .o_press (w_run_press)
  );

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_db_step (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_step),
    .o_press (w_step_press)
  );

  assign w_cpu_en  = rc_core_en(r_state, halted);
  assign cpu_en    = w_cpu_en;
  assign running   = (r_state == RC_ST_RUN);
  assign is_halted = (r_state == RC_ST_HALT);
  assign stat_out  = r_stat;

  // Next state: halted beats a run press, which beats a step press; HALT only exits on rst.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RC_ST_PAUSE: begin
        if (halted)            w_state_nxt = RC_ST_HALT;
        else if (w_run_press)  w_state_nxt = RC_ST_RUN;
        else if (w_step_press) w_state_nxt = RC_ST_STEP;
      end
      RC_ST_RUN: begin
        if (halted)            w_state_nxt = RC_ST_HALT;
        else if (w_run_press)  w_state_nxt = RC_ST_PAUSE;
      end
      RC_ST_STEP: begin
        if (halted)            w_state_nxt = RC_ST_HALT;
        else                   w_state_nxt = RC_ST_PAUSE;
      end
      default:                 w_state_nxt = RC_ST_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RC_ST_PAUSE;
    else     r_state <= w_state_nxt;
  end

  // Statistics advance only in cycles the core actually executes; they wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= '0;
      r_jmp_cnt <= '0;
      r_br_cnt  <= '0;
      r_brt_cnt <= '0;
    end else if (w_cpu_en) begin
      r_cyc_cnt <= r_cyc_cnt + CntWidth'(1);
      r_jmp_cnt <= r_jmp_cnt + CntWidth'(jumped);
      r_br_cnt  <= r_br_cnt  + CntWidth'(is_branch);
      r_brt_cnt <= r_brt_cnt + CntWidth'(branched);
    end
  end

  // Register the selected counter; it shows the value before this cycle's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat <= '0;
    end else begin
      case (sel_stat)
        RC_STAT_SEL_CYC: r_stat <= r_cyc_cnt;
        RC_STAT_SEL_JMP: r_stat <= r_jmp_cnt;
        RC_STAT_SEL_BR:  r_stat <= r_br_cnt;
        default:         r_stat <= r_brt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl_stats.sv
// Testbench for run_ctrl_stats: a 32-bit and a 4-bit counter instance share all inputs
// and are compared every cycle against a behavioural model, plus literal edge checks.
module tb_run_ctrl_stats;

  localparam int D = 4;
  localparam int M_PAUSE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic        clk;
  logic        rst;
  logic        btn_run, btn_step, halted, jumped, is_branch, branched;
  logic [1:0]  sel_stat;
  logic        cpu_en, running, is_halted;
  logic [31:0] stat_out;
  logic        cpu_en_w, running_w, is_halted_w;
  logic [3:0]  stat_out_w;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 0;

  run_ctrl_stats #(.DebounceCycles(D), .CntWidth(32)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .halted(halted),
    .jumped(jumped), .is_branch(is_branch), .branched(branched), .sel_stat(sel_stat),
    .cpu_en(cpu_en), .running(running), .is_halted(is_halted), .stat_out(stat_out)
  );

  run_ctrl_stats #(.DebounceCycles(D), .CntWidth(4)) dut_w (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .halted(halted),
    .jumped(jumped), .is_branch(is_branch), .branched(branched), .sel_stat(sel_stat),
    .cpu_en(cpu_en_w), .running(running_w), .is_halted(is_halted_w), .stat_out(stat_out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int          m_st;
  logic [31:0] m_cyc, m_jmp, m_br, m_brt, m_stat;
  logic        m_s1 [2];
  logic        m_s2 [2];
  logic        m_db [2];
  logic        m_press [2];
  int          m_run [2];

  always @(posedge clk or posedge rst) begin : model
    logic en;
    logic raw;
    if (rst) begin
      m_st = M_PAUSE;
      m_cyc = 0; m_jmp = 0; m_br = 0; m_brt = 0; m_stat = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_press[b] = 0; m_run[b] = 0;
      end
    end else begin
      en = (m_st == M_RUN || m_st == M_STEP) && !halted;
      case (sel_stat)
        2'd0:    m_stat = m_cyc;
        2'd1:    m_stat = m_jmp;
        2'd2:    m_stat = m_br;
        default: m_stat = m_brt;
      endcase
      if (en) begin
        m_cyc += 1;
        m_jmp += 32'(jumped);
        m_br  += 32'(is_branch);
        m_brt += 32'(branched);
      end
      if (m_st != M_HALT) begin
        if (halted)                         m_st = M_HALT;
        else if (m_st == M_STEP)            m_st = M_PAUSE;
        else if (m_press[0])                m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        else if (m_press[1] && m_st == M_PAUSE) m_st = M_STEP;
      end
      // A level is accepted once the synchronized button has disagreed with it for D edges in a row.
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? btn_run : btn_step;
        m_press[b] = 0;
        if (m_s2[b] != m_db[b]) m_run[b]++;
        else                    m_run[b] = 0;
        if (m_run[b] == D) begin
          m_db[b] = m_s2[b];
          m_press[b] = m_s2[b];
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cpu_en",    32'(cpu_en),    32'((m_st == M_RUN || m_st == M_STEP) && !halted));
      chk("running",   32'(running),   32'(m_st == M_RUN));
      chk("is_halted", 32'(is_halted), 32'(m_st == M_HALT));
      chk("stat_out",  stat_out,       m_stat);
      chk("stat_out_w4", 32'(stat_out_w), 32'(m_stat[3:0]));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; btn_run = 0; btn_step = 0; halted = 0;
    jumped = 0; is_branch = 0; branched = 0; sel_stat = 0;
    repeat (2) @(posedge clk);
    #1;
    // 1. Reset
    chk("rst cpu_en", 32'(cpu_en), 0);
    chk("rst running", 32'(running), 0);
    chk("rst is_halted", 32'(is_halted), 0);
    rst = 0;
    cmp_on = 1;
    for (int i = 0; i < 4; i++) begin
      sel_stat = 2'(i);
      tick();
      chk("rst stat_out", stat_out, 0);
    end
    sel_stat = 0;

    // 2. Single step: cpu_en for exactly one cycle, 7 edges after the press
    btn_step = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("step cpu_en by edge", 32'(cpu_en), 32'(k == 7));
    end
    btn_step = 0;
    repeat (10) tick();
    chk("cyc after step 1", stat_out, 1);
    btn_step = 1;
    repeat (10) tick();
    btn_step = 0;
    repeat (10) tick();
    chk("cyc after step 2", stat_out, 2);

    // 3. Run/pause: RUN from edge 7; pause 7 edges after second press; 28 run cycles
    btn_run = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("running by edge", 32'(running), 32'(k >= 7));
    end
    btn_run = 0;
    repeat (20) tick();
    btn_run = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("pause cpu_en by edge", 32'(cpu_en), 32'(k < 7));
    end
    btn_run = 0;
    repeat (10) tick();
    chk("cyc after run", stat_out, 30);

    // 4. Statistics in RUN, then flags while paused must not count
    btn_run = 1;
    repeat (8) tick();
    btn_run = 0;
    for (int i = 0; i < 5; i++) begin
      jumped = (i < 3); is_branch = 1; branched = (i == 1 || i == 3);
      tick();
    end
    jumped = 0; is_branch = 0; branched = 0;
    btn_run = 1;
    repeat (8) tick();
    btn_run = 0;
    repeat (6) tick();
    jumped = 1; is_branch = 1; branched = 1;
    repeat (5) tick();
    jumped = 0; is_branch = 0; branched = 0;
    sel_stat = 1; tick(); chk("jmp_cnt", stat_out, 3);
    sel_stat = 2; tick(); chk("br_cnt", stat_out, 5);
    sel_stat = 3; tick(); chk("brt_cnt", stat_out, 2);
    sel_stat = 0;

    // 5. Halt: immediate cpu_en drop, HALT next edge, presses ignored, rst exits
    btn_run = 1;
    repeat (8) tick();
    btn_run = 0;
    repeat (3) tick();
    halted = 1;
    #1;
    chk("halt same-cycle cpu_en", 32'(cpu_en), 0);
    tick();
    chk("halt is_halted", 32'(is_halted), 1);
    btn_run = 1; repeat (8) tick(); btn_run = 0; repeat (6) tick();
    btn_step = 1; repeat (8) tick(); btn_step = 0; repeat (6) tick();
    halted = 0;
    tick();
    chk("halt sticky", 32'(is_halted), 1);
    chk("halt no en", 32'(cpu_en), 0);
    rst = 1; tick(); rst = 0;
    chk("rst leaves halt", 32'(is_halted), 0);
    chk("rst leaves halt run", 32'(running), 0);

    // 6. Glitch of 3 cycles is rejected; then async reset mid-RUN at cyc_cnt=50
    btn_run = 1; repeat (3) tick(); btn_run = 0;
    repeat (12) tick();
    chk("glitch running", 32'(running), 0);
    btn_run = 1; repeat (8) tick(); btn_run = 0;
    repeat (49) tick();
    chk("cyc pre-update at 50", stat_out, 49);
    chk("still running", 32'(running), 1);
    #2;
    rst = 1;
    #1;
    chk("async rst cpu_en", 32'(cpu_en), 0);
    chk("async rst stat", stat_out, 0);
    tick();
    rst = 0;

    // 7. Wrap: 17 run cycles on a 4-bit counter reads 1
    btn_run = 1; repeat (8) tick(); btn_run = 0;
    repeat (16) tick();
    halted = 1;
    tick();
    chk("cyc 32-bit 17", stat_out, 17);
    chk("cyc 4-bit wrap", 32'(stat_out_w), 1);
    halted = 0;
    rst = 1; tick(); rst = 0;
    tick();

    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
